// File: rtl/redmule_pkg.sv
// Shared lane geometry and splitter state encoding for the RedMulE TCDM lane splitter.
package redmule_pkg;
  localparam int LANE_DW  = 32;
  localparam int LANE_BEW = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PARTIAL = 1'b1
  } lane_split_state_e;
endpackage

// File: rtl/redmule_lane_rsp_fifo.sv
// Per-lane synchronous response FIFO; holds lane read data until every lane of a wide response is present.
module redmule_lane_rsp_fifo
  import redmule_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [LANE_DW-1:0] data_i,
  output logic [LANE_DW-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(Depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

  logic [LANE_DW-1:0] mem [Depth];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      cnt;
  logic               do_push, do_pop;

  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO may still accept a push in the same cycle it is popped.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end
endmodule

// File: rtl/redmule_tcdm_lane_splitter.sv
// Splits a wide RedMulE TCDM request into independent 32b lanes and reassembles the lane responses.
// Optional perf counters are built when REDMULE_LANE_SPLIT_PERF_EN is defined.
module redmule_tcdm_lane_splitter
  import redmule_pkg::*;
#(
  parameter int NumLanes   = 8,
  parameter int AddrWidth  = 32,
  parameter int LaneStride = 4,
  parameter int RspDepth   = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wide_req_i,
  output logic                            wide_gnt_o,
  input  logic [AddrWidth-1:0]            wide_add_i,
  input  logic                            wide_wen_i,
  input  logic [LANE_BEW*NumLanes-1:0]    wide_be_i,
  input  logic [LANE_DW*NumLanes-1:0]     wide_data_i,
  output logic                            wide_r_valid_o,
  output logic [LANE_DW*NumLanes-1:0]     wide_r_data_o,
  output logic [NumLanes-1:0]             lane_req_o,
  input  logic [NumLanes-1:0]             lane_gnt_i,
  output logic [NumLanes*AddrWidth-1:0]   lane_add_o,
  output logic [NumLanes-1:0]             lane_wen_o,
  output logic [NumLanes*LANE_BEW-1:0]    lane_be_o,
  output logic [NumLanes*LANE_DW-1:0]     lane_data_o,
  input  logic [NumLanes-1:0]             lane_r_valid_i,
  input  logic [NumLanes*LANE_DW-1:0]     lane_r_data_i
`ifdef REDMULE_LANE_SPLIT_PERF_EN
  ,
  output logic [31:0]                     perf_partial_o,
  output logic [31:0]                     perf_txn_o
`endif
);
  localparam int CW = $clog2(RspDepth + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RspDepth);

  lane_split_state_e          state_q;
  logic [NumLanes-1:0]        granted_q, lane_req, gnt_eff, gnt_all;
  logic [CW-1:0]              credit_q;
  logic                       can_issue, first_gnt, rst_d_q;
  logic [NumLanes-1:0]        push, avail, empty, full, fifo_push, fifo_pop;
  logic                       pop_all;
  logic [NumLanes*LANE_DW-1:0] rsp_cat, rsp_data_p1;
  logic                       vld_p1;

  assign can_issue  = (state_q == PARTIAL) || (credit_q < CREDIT_MAX);
  assign lane_req   = rst_i ? '0 : ({NumLanes{wide_req_i & can_issue}} & ~granted_q);
  assign lane_req_o = lane_req;
  assign gnt_eff    = lane_gnt_i & lane_req;
  assign gnt_all    = granted_q | gnt_eff;
  assign wide_gnt_o = ~rst_i & wide_req_i & can_issue & (&gnt_all);
  assign first_gnt  = (state_q == IDLE) && (|gnt_eff);

  assign lane_wen_o  = {NumLanes{wide_wen_i}};
  assign lane_be_o   = wide_be_i;
  assign lane_data_o = wide_data_i;

  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    assign lane_add_o[i*AddrWidth +: AddrWidth] = wide_add_i + AddrWidth'(i * LaneStride);

    // Responses landing during reset or the cycle after belong to a discarded transaction.
    assign push[i]      = lane_r_valid_i[i] & ~rst_i & ~rst_d_q;
    assign avail[i]     = ~empty[i] | push[i];
    assign fifo_push[i] = push[i] & ~(empty[i] & pop_all);
    assign fifo_pop[i]  = pop_all & ~empty[i];

    logic [LANE_DW-1:0] fifo_dout;

    redmule_lane_rsp_fifo #(
      .Depth (RspDepth)
    ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push[i]),
      .pop_i   (fifo_pop[i]),
      .data_i  (lane_r_data_i[i*LANE_DW +: LANE_DW]),
      .data_o  (fifo_dout),
      .empty_o (empty[i]),
      .full_o  (full[i])
    );

    assign rsp_cat[i*LANE_DW +: LANE_DW] = empty[i] ? lane_r_data_i[i*LANE_DW +: LANE_DW] : fifo_dout;
  end

  assign pop_all = &avail;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      granted_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((|gnt_eff) && !(&gnt_eff)) begin
            granted_q <= gnt_eff;
            state_q   <= PARTIAL;
          end
        end
        PARTIAL: begin
          if (&gnt_all) begin
            granted_q <= '0;
            state_q   <= IDLE;
          end else begin
            granted_q <= gnt_all;
          end
        end
        default: begin
          granted_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q <= '0;
    end else begin
      case ({first_gnt, vld_p1})
        2'b10:   credit_q <= credit_q + CW'(1);
        2'b01:   credit_q <= credit_q - CW'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    rst_d_q <= rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(|(fifo_push & full & ~fifo_pop)))
        else $error("lane response FIFO overflow");
    end
  end

  // p1: registered wide response
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= pop_all;
  end

  always_ff @(posedge clk_i) begin
    if (pop_all) rsp_data_p1 <= rsp_cat;
  end

  assign wide_r_valid_o = vld_p1;
  assign wide_r_data_o  = rsp_data_p1;

`ifdef REDMULE_LANE_SPLIT_PERF_EN
  logic [31:0] perf_partial_q, perf_txn_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_partial_q <= '0;
      perf_txn_q     <= '0;
    end else begin
      if (state_q == PARTIAL) perf_partial_q <= perf_partial_q + 32'd1;
      if (vld_p1)             perf_txn_q     <= perf_txn_q + 32'd1;
    end
  end

  assign perf_partial_o = perf_partial_q;
  assign perf_txn_o     = perf_txn_q;
`endif
endmodule

// File: tb/tb_redmule_tcdm_lane_splitter.sv
// Directed bench for redmule_tcdm_lane_splitter: vector table for request fan-out plus grant/response sequences.
module tb_redmule_tcdm_lane_splitter;
  logic         clk = 1'b0;
  logic         rst;
  logic         wide_req, wide_gnt, wide_wen, wide_r_valid;
  logic [31:0]  wide_add, wide_be;
  logic [255:0] wide_data, wide_r_data;
  logic [7:0]   lane_req, lane_gnt, lane_wen, lane_r_valid;
  logic [255:0] lane_add, lane_data, lane_r_data;
  logic [31:0]  lane_be;
`ifdef REDMULE_LANE_SPLIT_PERF_EN
  logic [31:0]  perf_partial, perf_txn;
`endif

  int nvec  = 0;
  int nfail = 0;

  redmule_tcdm_lane_splitter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wide_req_i     (wide_req),
    .wide_gnt_o     (wide_gnt),
    .wide_add_i     (wide_add),
    .wide_wen_i     (wide_wen),
    .wide_be_i      (wide_be),
    .wide_data_i    (wide_data),
    .wide_r_valid_o (wide_r_valid),
    .wide_r_data_o  (wide_r_data),
    .lane_req_o     (lane_req),
    .lane_gnt_i     (lane_gnt),
    .lane_add_o     (lane_add),
    .lane_wen_o     (lane_wen),
    .lane_be_o      (lane_be),
    .lane_data_o    (lane_data),
    .lane_r_valid_i (lane_r_valid),
    .lane_r_data_i  (lane_r_data)
`ifdef REDMULE_LANE_SPLIT_PERF_EN
    ,
    .perf_partial_o (perf_partial),
    .perf_txn_o     (perf_txn)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = base + 32'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    wide_req = 1'b0; wide_add = '0; wide_wen = 1'b1; wide_be = '1; wide_data = '0;
    lane_gnt = '0; lane_r_valid = '0; lane_r_data = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] be;
    logic [31:0] dbase;
    logic [7:0]  exp_req;
    logic [31:0] exp_add0;
    logic [31:0] exp_add7;
    logic [7:0]  exp_wen;
  } vec_t;

  vec_t vecs[4];
  int   vcount;

  initial begin
    vecs[0] = '{1'b1, 32'h1C010000, 1'b1, 32'hFFFFFFFF, 32'hA000, 8'hFF, 32'h1C010000, 32'h1C01001C, 8'hFF};
    vecs[1] = '{1'b1, 32'h00001000, 1'b0, 32'h0000F00F, 32'h5000, 8'hFF, 32'h00001000, 32'h0000101C, 8'h00};
    vecs[2] = '{1'b1, 32'hFFFFFFF0, 1'b1, 32'h00000000, 32'h7000, 8'hFF, 32'hFFFFFFF0, 32'h0000000C, 8'hFF};
    vecs[3] = '{1'b0, 32'h12345678, 1'b1, 32'hF0F0F0F0, 32'h9000, 8'h00, 32'h12345678, 32'h12345694, 8'hFF};

    idle_in();
    rst = 1'b1;
    wide_req = 1'b1;
    lane_gnt = 8'hFF;
    @(negedge clk);
    chk("rst_lane_req", lane_req, 8'h00);
    chk("rst_wide_gnt", wide_gnt, 1'b0);
    step;
    @(negedge clk);
    chk("rst_r_valid", wide_r_valid, 1'b0);
    idle_in();
    rst = 1'b0;
    step;

    // Request fan-out with no grants: state must not move.
    for (int v = 0; v < 4; v++) begin
      wide_req  = vecs[v].req;
      wide_add  = vecs[v].add;
      wide_wen  = vecs[v].wen;
      wide_be   = vecs[v].be;
      wide_data = mk(vecs[v].dbase);
      @(negedge clk);
      chk($sformatf("v%0d_lane_req", v), lane_req, vecs[v].exp_req);
      chk($sformatf("v%0d_wide_gnt", v), wide_gnt, 1'b0);
      chk($sformatf("v%0d_add0", v), lane_add[31:0], vecs[v].exp_add0);
      chk($sformatf("v%0d_add7", v), lane_add[255:224], vecs[v].exp_add7);
      chk($sformatf("v%0d_be", v), lane_be, vecs[v].be);
      chk($sformatf("v%0d_wen", v), lane_wen, vecs[v].exp_wen);
      chk($sformatf("v%0d_data", v), lane_data, mk(vecs[v].dbase));
      step;
    end
    idle_in();
    step;

    // T1: single-cycle grant, read
    wide_req = 1'b1; wide_add = 32'h1C010000; wide_wen = 1'b1; lane_gnt = 8'hFF;
    @(negedge clk);
    chk("t1_wide_gnt", wide_gnt, 1'b1);
    chk("t1_add7", lane_add[255:224], 32'h1C01001C);
    step;
    idle_in();
    lane_r_valid = 8'hFF; lane_r_data = mk(32'h100);
    @(negedge clk);
    chk("t1_no_early_vld", wide_r_valid, 1'b0);
    step;
    idle_in();
    @(negedge clk);
    chk("t1_vld", wide_r_valid, 1'b1);
    chk("t1_data", wide_r_data, mk(32'h100));
    step;
    @(negedge clk);
    chk("t1_vld_drop", wide_r_valid, 1'b0);
    step;

    // T2: split grant (after a reset so perf counters start clean)
    do_reset();
    step;
    wide_req = 1'b1; wide_add = 32'h2000; wide_wen = 1'b1; lane_gnt = 8'h0F;
    @(negedge clk);
    chk("t2_c0_gnt", wide_gnt, 1'b0);
    chk("t2_c0_req", lane_req, 8'hFF);
    step;
    for (int c = 1; c <= 3; c++) begin
      lane_gnt = (c == 3) ? 8'hF0 : 8'h00;
      @(negedge clk);
      chk($sformatf("t2_c%0d_req", c), lane_req, 8'hF0);
      chk($sformatf("t2_c%0d_gnt", c), wide_gnt, (c == 3) ? 1'b1 : 1'b0);
      step;
    end
    idle_in();
    lane_r_valid = 8'hFF; lane_r_data = mk(32'h200);
    @(negedge clk);
    chk("t2_c4_vld", wide_r_valid, 1'b0);
    chk("t2_c4_req", lane_req, 8'h00);
    step;
    idle_in();
    @(negedge clk);
    chk("t2_c5_vld", wide_r_valid, 1'b1);
    chk("t2_c5_data", wide_r_data, mk(32'h200));
    step;
`ifdef REDMULE_LANE_SPLIT_PERF_EN
    @(negedge clk);
    chk("t6_perf_partial", perf_partial, 32'd3);
    chk("t6_perf_txn", perf_txn, 32'd1);
`endif
    step;

    // T3: credit limit with responses held off
    wide_req = 1'b1; wide_add = 32'h3000; lane_gnt = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin lane_r_valid = 8'hFF; lane_r_data = mk(32'hA00); end
      else lane_r_valid = 8'h00;
      @(negedge clk);
      chk($sformatf("t3_c%0d_req", c), lane_req, (c < 2) ? 8'hFF : 8'h00);
      chk($sformatf("t3_c%0d_gnt", c), wide_gnt, (c < 2) ? 1'b1 : 1'b0);
      if (c == 5) chk("t3_a_data", wide_r_data, mk(32'hA00));
      chk($sformatf("t3_c%0d_vld", c), wide_r_valid, (c == 5) ? 1'b1 : 1'b0);
      step;
    end
    lane_r_valid = 8'h00;
    @(negedge clk);
    chk("t3_c6_req", lane_req, 8'hFF);
    chk("t3_c6_gnt", wide_gnt, 1'b1);
    step;
    idle_in();
    for (int c = 7; c <= 12; c++) begin
      case (c)
        7:  begin lane_r_valid = 8'h0F; lane_r_data = mk(32'hB00); end
        8:  begin lane_r_valid = 8'h0F; lane_r_data = mk(32'hC00); end
        9:  begin lane_r_valid = 8'hF0; lane_r_data = mk(32'hB00); end
        10: begin lane_r_valid = 8'hF0; lane_r_data = mk(32'hC00); end
        default: begin lane_r_valid = 8'h00; lane_r_data = '0; end
      endcase
      @(negedge clk);
      chk($sformatf("t3_c%0d_vld", c), wide_r_valid, (c == 10 || c == 11) ? 1'b1 : 1'b0);
      if (c == 10) chk("t3_b_data", wide_r_data, mk(32'hB00));
      if (c == 11) chk("t3_c_data", wide_r_data, mk(32'hC00));
      step;
    end

    // T4: write, lane responses trickle in one lane per cycle
    idle_in();
    wide_req = 1'b1; wide_add = 32'h4000; wide_wen = 1'b0; wide_be = 32'h0000000F;
    wide_data = mk(32'hD00); lane_gnt = 8'hFF;
    @(negedge clk);
    chk("t4_be", lane_be, 32'h0000000F);
    chk("t4_wen", lane_wen, 8'h00);
    chk("t4_gnt", wide_gnt, 1'b1);
    step;
    idle_in();
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      lane_r_valid = (k < 8) ? (8'h01 << k) : 8'h00;
      @(negedge clk);
      if (wide_r_valid) vcount++;
      chk($sformatf("t4_k%0d_vld", k), wide_r_valid, (k == 8) ? 1'b1 : 1'b0);
      step;
    end
    chk("t4_vld_count", 256'(vcount), 256'd1);

    // T5: reset while PARTIAL with two FIFOs loaded
    idle_in();
    wide_req = 1'b1; wide_add = 32'h5000; lane_gnt = 8'h0F;
    step;
    lane_gnt = 8'h00; lane_r_valid = 8'h03; lane_r_data = mk(32'hE00);
    step;
    lane_r_valid = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_req", lane_req, 8'h00);
    step;
    rst = 1'b0;
    lane_gnt = 8'hFF; lane_r_valid = 8'hFC; lane_r_data = mk(32'hE00);
    @(negedge clk);
    chk("t5_c3_req", lane_req, 8'hFF);
    chk("t5_c3_gnt", wide_gnt, 1'b1);
    chk("t5_c3_vld", wide_r_valid, 1'b0);
    step;
    lane_r_valid = 8'h00;
    @(negedge clk);
    chk("t5_c4_req", lane_req, 8'hFF);
    chk("t5_c4_gnt", wide_gnt, 1'b1);
    chk("t5_c4_vld", wide_r_valid, 1'b0);
    step;
    wide_req = 1'b0; lane_gnt = 8'h00;
    lane_r_valid = 8'hFF; lane_r_data = mk(32'h600);
    @(negedge clk);
    chk("t5_c5_vld", wide_r_valid, 1'b0);
    step;
    lane_r_valid = 8'hFF; lane_r_data = mk(32'h700);
    @(negedge clk);
    chk("t5_c6_vld", wide_r_valid, 1'b1);
    chk("t5_d_data", wide_r_data, mk(32'h600));
    step;
    idle_in();
    @(negedge clk);
    chk("t5_c7_vld", wide_r_valid, 1'b1);
    chk("t5_e_data", wide_r_data, mk(32'h700));
    step;
    @(negedge clk);
    chk("t5_c8_vld", wide_r_valid, 1'b0);
    step;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
